// File: rtl/mul4_dot_acc_if.sv
// Operand-in / result-out handshake bundle for the dot-product accumulator.
// master drives operands and consumes results; slave is the accumulator side.
interface mul4_dot_acc_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/mul4_dot_acc.sv
// 4-bit dot-product accumulator: carry-save 4x4 multiplier, registered product
// stage, registered accumulate stage, one result per in_last-terminated packet.
module csa_mul_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // s/c hold the redundant partial sum; one full-adder row per multiplier bit
  logic [3:0] s, c, ns, nc, hi;
  logic [4:0] s_ext;

  always_comb begin
    s     = a & {4{b[0]}};
    c     = '0;
    ns    = '0;
    nc    = '0;
    s_ext = '0;
    hi    = '0;
    p     = '0;
    p[0]  = s[0];
    for (int i = 1; i < 4; i++) begin
      s_ext = {1'b0, s};
      for (int j = 0; j < 4; j++) begin
        ns[j] = (a[j] & b[i]) ^ s_ext[j+1] ^ c[j];
        nc[j] = ((a[j] & b[i]) & s_ext[j+1]) | ((a[j] & b[i]) & c[j]) | (s_ext[j+1] & c[j]);
      end
      s    = ns;
      c    = nc;
      p[i] = s[0];
    end
    // final carry-propagate resolves the upper nibble; the product fits in 8 bits
    hi     = {1'b0, s[3:1]} + c;
    p[7:4] = hi;
  end
endmodule

module mul4_dot_acc #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  mul4_dot_acc_if.slave bus
);
  logic [7:0]       prod;
  logic             p_vld, p_last;
  logic [7:0]       p_reg;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_st;
  logic             o_vld, o_ovf;
  logic [ACC_W-1:0] o_data;
  logic [CNT_W-1:0] o_cnt;
  logic [ACC_W:0]   sum;
  logic             p_adv, accept;

  csa_mul_4b u_mul (.a(bus.in_a), .b(bus.in_b), .p(prod));

  // only a last product waiting on an unconsumed result can stall the pipe
  assign p_adv  = p_vld & ~(p_last & o_vld & ~bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign sum    = {1'b0, acc} + (ACC_W+1)'(p_reg);

  assign bus.in_ready  = ~rst & (~p_vld | p_adv);
  assign bus.out_valid = o_vld;
  assign bus.out_data  = o_data;
  assign bus.out_count = o_cnt;
  assign bus.out_ovf   = o_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
      p_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf_st <= 1'b0;
      o_vld  <= 1'b0;
      o_data <= '0;
      o_cnt  <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        p_reg  <= prod;
        p_last <= bus.in_last;
        p_vld  <= 1'b1;
      end else if (p_adv) begin
        p_vld  <= 1'b0;
      end

      if (o_vld & bus.out_ready) o_vld <= 1'b0;

      if (p_adv) begin
        if (!p_last) begin
          acc    <= sum[ACC_W-1:0];
          cnt    <= cnt + CNT_W'(1);
          ovf_st <= ovf_st | sum[ACC_W];
        end else begin
          // a fresh result overrides the consume-clear above
          o_data <= sum[ACC_W-1:0];
          o_cnt  <= cnt + CNT_W'(1);
          o_ovf  <= ovf_st | sum[ACC_W];
          o_vld  <= 1'b1;
          acc    <= '0;
          cnt    <= '0;
          ovf_st <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/mul4_dot_acc.md
Name: mul4_dot_acc

Overview:
- Downstream consumer of the 4x4 carry-save array multiplier (csa_mul_4b). It instantiates one multiplier combinationally on the accepted operand pair.
- Accumulates a stream of 4-bit operand pairs into a dot product, one packet at a time; packet end is marked by in_last.
- Registered product stage plus registered accumulate stage, valid/ready handshake on both sides.
- Sits between the operand sequencer and the result writeback logic.

Parameters:
- ACC_W, 16, accumulator/result width in bits; must be >= 8.
- CNT_W, 8, element-count width; count wraps modulo 2^CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  4  unsigned operand A.
- in_b  input  4  unsigned operand B.
- in_last  input  1  marks the final pair of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  dot product modulo 2^ACC_W.
- out_count  output  CNT_W  number of pairs in the packet, modulo 2^CNT_W.
- out_ovf  output  1  sticky: some accumulate in the packet carried out of ACC_W.

Behaviour:
- Reset (synchronous, rst high at an edge) clears all registers: p_vld, p_reg, p_last, acc, cnt, ovf_st, out_valid, out_data, out_count, out_ovf all 0. in_ready is 0 while rst is high.
- Input accept: in_valid & in_ready at an edge. p_reg <= in_a*in_b (8-bit, from the multiplier), p_last <= in_last, p_vld <= 1.
- Accumulate advance: p_adv = p_vld & ~(p_last & out_valid & ~out_ready).
- in_ready = ~rst & (~p_vld | p_adv), combinational. A non-last product never stalls.
- On p_adv with p_last = 0:
  - acc <= acc + zero-extended p_reg, modulo 2^ACC_W.
  - cnt <= cnt + 1.
  - ovf_st <= ovf_st | carry-out.
- On p_adv with p_last = 1:
  - out_data <= acc + p_reg.
  - out_count <= cnt + 1.
  - out_ovf <= ovf_st | carry.
  - out_valid <= 1.
  - acc, cnt and ovf_st are cleared to 0.
- If p_vld is high and p_adv is low: p_reg, p_last, acc and cnt hold.
- p_vld clears on p_adv when no new input is accepted the same edge. Accept and advance on the same edge give a seamless handoff.
- Output handshake:
  - out_valid & out_ready at an edge clears out_valid, unless a new result loads on the same edge, in which case out_valid stays 1 with the new data.
  - out_data, out_count and out_ovf hold stable while out_valid & ~out_ready.
- Latency: pair accepted at edge n -> p_vld at edge n. A last pair -> out_valid high after edge n+1 (2-cycle latency). Throughput is 1 pair/cycle when out_ready is held high.
- Boundaries:
  - A single-element packet is legal, giving out_count = 1.
  - Packets with more than 2^CNT_W-1 pairs wrap out_count.
  - ACC_W = 8 exposes wrap with the ovf flag.
  - rst mid-packet discards the partial sum and any pending or unaccepted result; the next accepted pair starts a new packet.
  - X on in_a/in_b is ignored when in_valid = 0.

Test Plan:
1. Pairs (3,5),(15,15),(7,2,last) on consecutive cycles, out_ready=1 -> out_valid for 1 cycle, 2 cycles after the last accept; out_data=254, out_count=3, out_ovf=0.
2. Back-to-back single packets (15,15,last),(1,1,last),(0,9,last), out_ready=1 -> results 225, 1, 0 on 3 consecutive cycles, each count=1; in_ready never drops.
3. out_ready=0 while 254 is pending, then send (2,2),(4,4,last):
   - (2,2) absorbs; (4,4,last) waits in p_reg and in_ready=0.
   - out_data holds 254 stable.
   - Raise out_ready for 1 cycle -> next cycle out_data=20, count=2.
4. ACC_W=8: (15,15),(15,15,last) -> out_data=194, out_ovf=1. A following (1,1,last) -> out_data=1, out_ovf=0.
5. Accept (5,5),(6,6), assert rst 1 cycle, then (2,3,last) -> out_data=6, out_count=1. All outputs read 0 during and right after rst.
6. CNT_W=2: 5 pairs of (1,1), last on the 5th -> out_data=5, out_count=1 (wrapped).
